// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, and a fixed-latency
// mul/div front-end hold, plus a saturating stall-cycle counter for performance debug.
module hazard_ctrl #(
  parameter int MD_LAT = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             md_start,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_nop,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [7:0]       MD_LAT_M1 = 8'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic             pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic stall_c, flush_c, busy_c;

  // Load-use is purely combinational on the current ID/EX fields; r0 never hazards.
  always_comb begin
    lu = ex_memread && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pend_flush_d = pend_flush_q;
    stall_c      = 1'b0;
    flush_c      = 1'b0;
    busy_c       = 1'b0;

    case (state_q)
      RUN: begin
        if (branch_taken || pend_flush_q) begin
          flush_c      = 1'b1;
          pend_flush_d = 1'b0;
        end else if (lu) begin
          stall_c = 1'b1;
        end
        if (md_start) begin
          state_d  = MD_WAIT;
          md_cnt_d = MD_LAT_M1;
        end
      end
      MD_WAIT: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        // A redirect resolved while frozen is remembered and applied on the first RUN cycle.
        if (branch_taken) pend_flush_d = 1'b1;
        if (md_cnt_q == 8'd0) state_d = RUN;
        else                  md_cnt_d = md_cnt_q - 8'd1;
      end
      default: state_d = RUN;
    endcase

    // Controls are forced low while reset is held, independent of live inputs.
    if (rst) begin
      stall_c = 1'b0;
      flush_c = 1'b0;
      busy_c  = 1'b0;
    end

    stall_cnt_d = (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + CNT_ONE
                                                             : stall_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      md_cnt_q     <= 8'd0;
      pend_flush_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      pend_flush_q <= pend_flush_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign pc_stall   = stall_c;
  assign ifid_stall = stall_c;
  assign idex_nop   = stall_c;
  assign ifid_flush = flush_c;
  assign md_busy    = busy_c;
  assign stall_cnt  = stall_cnt_q;

endmodule
